// File: rtl/mem_bank_if.sv
// Bus bundle for the mem_bank storage: request side driven by the datapath,
// read data and the misalignment flag returned by the bank.
interface mem_bank_if;
  logic        memread;
  logic        memwrite;
  logic [7:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteen;
  logic [31:0] readdata;
  logic        misaligned;

  modport master (
    output memread, memwrite, address, writedata, byteen,
    input  readdata, misaligned
  );

  modport slave (
    input  memread, memwrite, address, writedata, byteen,
    output readdata, misaligned
  );
endinterface

// File: rtl/mem_bank.sv
// Word-organised data memory with byte addressing and per-byte write enables.
// Reads are registered and return the contents from before any write on the
// same edge. Bits [1:0] of the address never change which word is selected.
module mem_bank #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_bank_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int NLANE = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_readdata;
  logic [AW-1:0]     w_idx;

  assign w_idx = bus.address[AW+1:2];

  // Storage and read register: cleared by reset. The read samples the old word
  // because the write to the same word only lands at the end of this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_readdata <= '0;
    end else begin
      if (bus.memwrite) begin
        for (int k = 0; k < NLANE; k++) begin
          if (bus.byteen[k]) begin
            r_mem[w_idx][8*k +: 8] <= bus.writedata[8*k +: 8];
          end
        end
      end
      if (bus.memread) begin
        r_readdata <= r_mem[w_idx];
      end
    end
  end

  assign bus.readdata   = r_readdata;
  // Flag only; the access still goes to the word selected by address[7:2].
  assign bus.misaligned = (bus.memread | bus.memwrite) & (bus.address[1:0] != 2'b00);

endmodule

// File: tb/tb_mem_bank.sv
// Self-checking bench for mem_bank: directed scenarios followed by random traffic,
// all compared against a word-array reference model held in the bench.
module tb_mem_bank;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [31:0] m_mem [64];
  logic [31:0] m_rd;

  mem_bank_if bus ();

  mem_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
    m_rd = 32'h0;
  endtask

  // Advance one rising edge, updating the model from the inputs presented for it.
  task automatic step();
    int w;
    w = int'(bus.address) / 4;
    if (rst_n) begin
      if (bus.memread) m_rd = m_mem[w];
      if (bus.memwrite)
        for (int k = 0; k < 4; k++)
          if (bus.byteen[k]) m_mem[w][8*k +: 8] = bus.writedata[8*k +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.byteen    = 4'h0;
    bus.writedata = 32'h0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    idle();
    bus.memwrite  = 1'b1;
    bus.address   = a;
    bus.writedata = d;
    bus.byteen    = be;
    step();
    idle();
  endtask

  task automatic do_read(input logic [7:0] a);
    idle();
    bus.memread = 1'b1;
    bus.address = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.address = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_value readdata=%h expected=%h", bus.readdata, 32'h0);
    end
    do_write(8'h10, 32'hDEADBEEF, 4'hF);
    do_read(8'h10);
    n_checks++;
    if (bus.readdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL reset_pre readdata=%h expected=%h", bus.readdata, 32'hDEADBEEF);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_async readdata=%h expected=%h", bus.readdata, 32'h0);
    end
    // Write attempt while reset is held must be ignored.
    bus.memwrite = 1'b1; bus.address = 8'h14; bus.writedata = 32'h55AA55AA; bus.byteen = 4'hF;
    #1;
    n_checks++;
    if (bus.misaligned !== 1'b0) begin
      n_fail++; $display("FAIL reset_misaligned misaligned=%b expected=%b", bus.misaligned, 1'b0);
    end
    bus.address = 8'h15;
    #1;
    n_checks++;
    if (bus.misaligned !== 1'b1) begin
      n_fail++; $display("FAIL reset_misaligned2 misaligned=%b expected=%b", bus.misaligned, 1'b1);
    end
    bus.address = 8'h14;
    step();
    idle();
    rst_n = 1'b1;
    do_read(8'h10);
    n_checks++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_cleared readdata=%h expected=%h", bus.readdata, 32'h0);
    end
    do_read(8'h14);
    n_checks++;
    if (bus.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_no_write readdata=%h expected=%h", bus.readdata, 32'h0);
    end
  endtask

  task automatic test_full_word();
    do_write(8'h04, 32'h20010001, 4'hF);
    do_read(8'h04);
    n_checks++;
    if (bus.readdata !== 32'h20010001) begin
      n_fail++; $display("FAIL full_word readdata=%h expected=%h", bus.readdata, 32'h20010001);
    end
  endtask

  task automatic test_byte_en();
    do_write(8'h08, 32'hAABBCCDD, 4'hF);
    do_write(8'h08, 32'h11223344, 4'b0101);
    do_read(8'h08);
    n_checks++;
    if (bus.readdata !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL byte_en readdata=%h expected=%h", bus.readdata, 32'hAA22CC44);
    end
    do_write(8'h08, 32'hFFFFFFFF, 4'h0);
    do_read(8'h08);
    n_checks++;
    if (bus.readdata !== 32'hAA22CC44) begin
      n_fail++; $display("FAIL byte_en_zero readdata=%h expected=%h", bus.readdata, 32'hAA22CC44);
    end
  endtask

  task automatic test_rbw();
    do_write(8'h0C, 32'h12345678, 4'hF);
    idle();
    bus.memread = 1'b1; bus.memwrite = 1'b1; bus.address = 8'h0C;
    bus.writedata = 32'hCAFEF00D; bus.byteen = 4'hF;
    step();
    idle();
    n_checks++;
    if (bus.readdata !== 32'h12345678) begin
      n_fail++; $display("FAIL rbw_old readdata=%h expected=%h", bus.readdata, 32'h12345678);
    end
    do_read(8'h0C);
    n_checks++;
    if (bus.readdata !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL rbw_new readdata=%h expected=%h", bus.readdata, 32'hCAFEF00D);
    end
  endtask

  task automatic test_hold_align();
    do_read(8'h0C);
    for (int a = 0; a <= 8'h7E; a++) begin
      bus.address = 8'(a);
      #1;
      n_checks++;
      if (bus.misaligned !== 1'b0) begin
        n_fail++; $display("FAIL hold_misaligned addr=%h misaligned=%b expected=0", a, bus.misaligned);
      end
      step();
      n_checks++;
      if (bus.readdata !== 32'hCAFEF00D) begin
        n_fail++; $display("FAIL hold addr=%h readdata=%h expected=%h", a, bus.readdata, 32'hCAFEF00D);
      end
    end
    bus.memread = 1'b1; bus.address = 8'h05;
    #1;
    n_checks++;
    if (bus.misaligned !== 1'b1) begin
      n_fail++; $display("FAIL align_flag misaligned=%b expected=%b", bus.misaligned, 1'b1);
    end
    step();
    idle();
    n_checks++;
    if (bus.readdata !== 32'h20010001) begin
      n_fail++; $display("FAIL align_word readdata=%h expected=%h", bus.readdata, 32'h20010001);
    end
  endtask

  task automatic test_wrap_sweep();
    for (int k = 0; k < 64; k++) do_write(8'(4 * k), 32'(k), 4'hF);
    do_read(8'hFC);
    n_checks++;
    if (bus.readdata !== 32'd63) begin
      n_fail++; $display("FAIL wrap_fc readdata=%h expected=%h", bus.readdata, 32'd63);
    end
    do_read(8'h00);
    n_checks++;
    if (bus.readdata !== 32'd0) begin
      n_fail++; $display("FAIL wrap_00 readdata=%h expected=%h", bus.readdata, 32'd0);
    end
    do_read(8'hFF);
    n_checks++;
    if (bus.readdata !== 32'd63) begin
      n_fail++; $display("FAIL wrap_ff readdata=%h expected=%h", bus.readdata, 32'd63);
    end
    for (int k = 0; k < 64; k++) begin
      do_read(8'(4 * k + 3));
      n_checks++;
      if (bus.readdata !== 32'(k)) begin
        n_fail++; $display("FAIL sweep word=%0d readdata=%h expected=%h", k, bus.readdata, 32'(k));
      end
    end
  endtask

  task automatic test_random();
    logic exp_mis;
    for (int n = 0; n < 400; n++) begin
      bus.memread   = 1'($urandom_range(0, 1));
      bus.memwrite  = 1'($urandom_range(0, 1));
      bus.address   = 8'($urandom_range(0, 255));
      bus.writedata = $urandom;
      bus.byteen    = 4'($urandom_range(0, 15));
      exp_mis = (bus.memread || bus.memwrite) && (bus.address % 4 != 0);
      #1;
      n_checks++;
      if (bus.misaligned !== exp_mis) begin
        n_fail++; $display("FAIL rand_misaligned iter=%0d misaligned=%b expected=%b", n, bus.misaligned, exp_mis);
      end
      step();
      n_checks++;
      if (bus.readdata !== m_rd) begin
        n_fail++; $display("FAIL rand_read iter=%0d readdata=%h expected=%h", n, bus.readdata, m_rd);
      end
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    bus.address = 8'h00;
    model_reset();
    test_reset();
    test_full_word();
    test_byte_en();
    test_rbw();
    test_hold_align();
    test_wrap_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
